// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU and load-unit results into one
// write port, draining one entry per cycle in strict FIFO order.
module writeback_queue #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]   alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDRESS_WIDTH-1:0]   mem_rd,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_ready,
  output logic                       WE3,
  output logic [ADDRESS_WIDTH-1:0]   AD3,
  output logic [DATA_WIDTH-1:0]      WD3,
  input  logic [ADDRESS_WIDTH-1:0]   chk1_addr,
  input  logic [ADDRESS_WIDTH-1:0]   chk2_addr,
  output logic                       chk1_pending,
  output logic                       chk2_pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] r_mem_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]    r_mem_data [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic [CNT_W-1:0]         w_free;
  logic                     w_empty;
  logic                     w_alu_push;
  logic                     w_mem_push;
  logic                     w_pop;
  logic [1:0]               w_push_cnt;
  logic [PTR_W-1:0]         w_mem_slot;
  logic [PTR_W-1:0]         w_off  [DEPTH];
  logic [DEPTH-1:0]         w_hit1;
  logic [DEPTH-1:0]         w_hit2;

  // Free space ignores this cycle's pop so a full queue never pushes and pops at once.
  assign w_free    = CNT_W'(DEPTH) - r_count;
  assign alu_ready = (w_free >= CNT_W'(1));
  assign mem_ready = alu_valid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1));

  // Accepted requests targeting x0 are swallowed without occupying a slot.
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign w_mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign w_push_cnt = {1'b0, w_alu_push} + {1'b0, w_mem_push};
  assign w_mem_slot = r_wr_ptr + PTR_W'(w_alu_push);

  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty;

  assign empty = w_empty;
  assign count = r_count;
  assign WE3   = !w_empty;
  assign AD3   = w_empty ? '0 : r_mem_rd[r_rd_ptr];
  assign WD3   = w_empty ? '0 : r_mem_data[r_rd_ptr];

  // An entry is occupied when its distance from the head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_scan
    assign w_off[g]  = PTR_W'(g) - r_rd_ptr;
    assign w_hit1[g] = ({1'b0, w_off[g]} < r_count) && (r_mem_rd[g] == chk1_addr);
    assign w_hit2[g] = ({1'b0, w_off[g]} < r_count) && (r_mem_rd[g] == chk2_addr);
  end

  assign chk1_pending = (chk1_addr != '0) && (|w_hit1);
  assign chk2_pending = (chk2_addr != '0) && (|w_hit2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count  <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop);
    end
  end

  // NOTE: entry storage has no reset; the count alone decides which slots are
  // valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_alu_push) begin
      r_mem_rd[r_wr_ptr]   <= alu_rd;
      r_mem_data[r_wr_ptr] <= alu_data;
    end
    if (w_mem_push) begin
      r_mem_rd[w_mem_slot]   <= mem_rd;
      r_mem_data[w_mem_slot] <= mem_data;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: a queue-based reference model is
// compared every cycle, plus hand-computed expectations for directed cases.
module tb_writeback_queue;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [AW-1:0]   alu_rd = '0;
  logic [DW-1:0]   alu_data = '0;
  logic            alu_ready;
  logic            mem_valid = 1'b0;
  logic [AW-1:0]   mem_rd = '0;
  logic [DW-1:0]   mem_data = '0;
  logic            mem_ready;
  logic            WE3;
  logic [AW-1:0]   AD3;
  logic [DW-1:0]   WD3;
  logic [AW-1:0]   chk1_addr = '0;
  logic [AW-1:0]   chk2_addr = '0;
  logic            chk1_pending;
  logic            chk2_pending;
  logic [$clog2(DEPTH):0] count;
  logic            empty;

  int   total = 0;
  int   bad   = 0;
  bit   check_en = 1'b0;
  entry_t q[$];

  writeback_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .WE3(WE3), .AD3(AD3), .WD3(WD3),
    .chk1_addr(chk1_addr), .chk2_addr(chk2_addr),
    .chk1_pending(chk1_pending), .chk2_pending(chk2_pending),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pending(input logic [AW-1:0] addr);
    if (addr == '0) return 1'b0;
    foreach (q[i]) if (q[i].rd == addr) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: queue semantics straight from the rules.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    int  free;
    bit  acc_alu, acc_mem;
    if (rst_n) begin
      free    = DEPTH - q.size();
      acc_alu = alu_valid && (free >= 1);
      acc_mem = mem_valid && (alu_valid ? (free >= 2) : (free >= 1));
      if (q.size() != 0) void'(q.pop_front());
      if (acc_alu && alu_rd != '0) q.push_back('{alu_rd, alu_data});
      if (acc_mem && mem_rd != '0) q.push_back('{mem_rd, mem_data});
    end
  end

  always @(negedge clk) begin
    int free;
    if (check_en) begin
      free = DEPTH - q.size();
      check("we3",       64'(WE3),       64'(q.size() != 0));
      check("ad3",       64'(AD3),       (q.size() != 0) ? 64'(q[0].rd)   : 64'd0);
      check("wd3",       64'(WD3),       (q.size() != 0) ? 64'(q[0].data) : 64'd0);
      check("count",     64'(count),     64'(q.size()));
      check("empty",     64'(empty),     64'(q.size() == 0));
      check("alu_ready", 64'(alu_ready), 64'(free >= 1));
      check("mem_ready", 64'(mem_ready), 64'(alu_valid ? (free >= 2) : (free >= 1)));
      check("chk1",      64'(chk1_pending), 64'(model_pending(chk1_addr)));
      check("chk2",      64'(chk2_pending), 64'(model_pending(chk2_addr)));
    end
  end

  // Drive one cycle of inputs just after the falling edge, return at the next one.
  task automatic cyc(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                     input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
    #1;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset state, with no clock edge needed.
    #3;
    check("rst_we3",   64'(WE3),   64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ad3",   64'(AD3),   64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);

    // Single push appears the cycle after acceptance, gone one edge later.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    check("single_we3", 64'(WE3), 64'd1);
    check("single_ad3", 64'(AD3), 64'd5);
    check("single_wd3", 64'(WD3), 64'hDEADBEEF);
    idle();
    check("single_empty", 64'(empty), 64'd1);

    // Dual push to the same rd: ALU first, load second.
    chk1_addr = 5'd3;
    cyc(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    check("dual_wd3_a",  64'(WD3),          64'h11);
    check("dual_pend_a", 64'(chk1_pending), 64'd1);
    check("dual_count",  64'(count),        64'd2);
    idle();
    check("dual_wd3_b",  64'(WD3),          64'h22);
    check("dual_pend_b", 64'(chk1_pending), 64'd1);
    idle();
    check("dual_pend_c", 64'(chk1_pending), 64'd0);
    check("dual_empty",  64'(empty),        64'd1);

    // x0 destinations are discarded.
    chk1_addr = '0;
    cyc(1'b1, '0, 32'hAAAA, 1'b0, '0, '0);
    check("x0_count", 64'(count),        64'd0);
    check("x0_we3",   64'(WE3),          64'd0);
    check("x0_pend",  64'(chk1_pending), 64'd0);
    cyc(1'b1, '0, 32'hBBBB, 1'b1, 5'd4, 32'h44);
    check("x0_mix_count", 64'(count), 64'd1);
    check("x0_mix_ad3",   64'(AD3),   64'd4);
    idle();

    // Ten single pushes walk the pointers around the ring.
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, AW'(i), DW'(i * 32'h100), 1'b0, '0, '0);
      check("wrap_ad3", 64'(AD3), 64'(i));
    end
    idle();
    check("wrap_empty", 64'(empty), 64'd1);

    // Backpressure: both producers always valid.
    chk2_addr = 5'd8;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, AW'((i % 30) + 1), DW'(32'hA000 + i),
          1'b1, AW'(((i + 7) % 30) + 1), DW'(32'hB000 + i));
      check("bp_count_le_depth", 64'(count <= DEPTH), 64'd1);
      if (i == 2) begin
        check("bp_count3",    64'(count),     64'd3);
        check("bp_mem_ready", 64'(mem_ready), 64'd0);
      end
    end
    repeat (4) idle();
    check("bp_drained", 64'(empty), 64'd1);

    // Reset while three entries are queued.
    cyc(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80);
    cyc(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0);
    check("mid_count3", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    check("mid_rst_we3",   64'(WE3),          64'd0);
    check("mid_rst_count", 64'(count),        64'd0);
    check("mid_rst_empty", 64'(empty),        64'd1);
    check("mid_rst_wd3",   64'(WD3),          64'd0);
    check("mid_rst_chk2",  64'(chk2_pending), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (3) begin
      idle();
      check("post_rst_we3", 64'(WE3), 64'd0);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, queue entries, a power of two and at least 2.
REQ-004 Ports SHALL be as follows; there is one clock, and reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDRESS_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  queue can accept an ALU request.
- mem_valid  in  1  load-unit writeback request.
- mem_rd  in  ADDRESS_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load result.
- mem_ready  out  1  queue can accept a load request.
- WE3  out  1  register-file write enable.
- AD3  out  ADDRESS_WIDTH  register-file write address.
- WD3  out  DATA_WIDTH  register-file write data.
- chk1_addr  in  ADDRESS_WIDTH  operand-1 address to check.
- chk2_addr  in  ADDRESS_WIDTH  operand-2 address to check.
- chk1_pending  out  1  write pending to chk1_addr.
- chk2_pending  out  1  write pending to chk2_addr.
- count  out  clog2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0.

Function
REQ-005 Storage SHALL be a circular FIFO of DEPTH entries {rd, data}, with write pointer, read pointer and occupancy counter, all updated on the rising edge of clk.
REQ-006 An ALU request SHALL be accepted on a clock edge when alu_valid && alu_ready is true.
REQ-007 A load request SHALL be accepted on a clock edge when mem_valid && mem_ready is true.
REQ-008 free SHALL equal DEPTH - count; the current-cycle pop SHALL NOT be credited.
REQ-009 alu_ready SHALL be asserted when free >= 1.
REQ-010 mem_ready SHALL be asserted when free >= 2 while alu_valid is high, and when free >= 1 while alu_valid is low.
REQ-011 When both requests are accepted in the same cycle, the ALU entry SHALL occupy slot wr_ptr and the load entry slot wr_ptr+1 (modulo DEPTH).
REQ-012 An accepted request with rd == 0 SHALL be consumed and discarded; it is not enqueued and does not advance wr_ptr or count.
REQ-013 WE3 SHALL equal !empty, combinationally.
REQ-014 AD3 and WD3 SHALL present the head entry combinationally, and SHALL be all-zero when empty.
REQ-015 The register file accepts a write every cycle, so the head SHALL be popped on every edge where empty is low: rd_ptr increments and count decrements by 1.
REQ-016 Latency SHALL be as follows:
- A request accepted at edge N into an empty queue SHALL appear on WE3/AD3/WD3 in the cycle after edge N and be popped at edge N+1.
- Each older queued entry SHALL add one cycle.
REQ-017 Per edge, count SHALL update as count + pushes (0..2) - pop (0..1); simultaneous push and pop on a full queue is impossible by REQ-008.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 without loss or duplication of entries.
REQ-019 chkN_pending SHALL be asserted combinationally iff chkN_addr != 0 and some occupied entry, head included, has rd == chkN_addr.
REQ-020 Entries SHALL drain in strict FIFO order.
REQ-021 Two entries with the same rd SHALL both be written, in order, so that the last-enqueued value remains in the register file.

Reset
REQ-022 While rst_n is low, wr_ptr, rd_ptr and count SHALL be 0, empty SHALL be 1, WE3 SHALL be 0, AD3 and WD3 SHALL be 0, and chk1_pending and chk2_pending SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard all queued entries immediately, with no partial write issued after assertion.
REQ-024 Entry storage SHALL NOT need to be reset.

Verification
REQ-025 Single push: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at edge 1 -> WE3=1, AD3=5, WD3=0xDEADBEEF in cycle 2, then empty=1 after edge 2.
REQ-026 Dual push order: at one edge, ALU (rd=3, 0x11) and load (rd=3, 0x22) -> consecutive writes 0x11 then 0x22, and chk1_addr=3 shows pending high until after the second pop.
REQ-027 Backpressure: hold alu_valid=1 and mem_valid=1 every cycle with DEPTH=4 -> count never exceeds 4, mem_ready drops when free < 2, and no accepted entry is lost (compare against a reference model).
REQ-028 x0 discard: alu_rd=0 accepted -> count stays 0, WE3 stays 0, and chk1_addr=0 gives chk1_pending=0.
REQ-029 Wrap-around: 10 sequential single pushes with rd=1..10 -> the AD3 sequence is 1..10 across the pointer wrap.
REQ-030 Reset mid-drain: fill 3 entries, assert rst_n=0 between edges -> WE3=0, count=0 immediately, and no writes follow release.
